flipflop: RTL and testbench
===========================

Name: flipflop

Overview:
- Clocked D-type storage element: samples `i_valor` on each rising edge of `clk` and presents it on `o_valor`.
- Generalised to a parameterised width and a parameterised number of back-to-back stages (delay line). Synchronous active-low clear.
- Basic registering/synchronising primitive; the default configuration is a single 1-bit D flip-flop.

Parameters:
- WIDTH, 1, bit width of `i_valor`/`o_valor`; legal range 1..64.
- DEPTH, 1, number of cascaded register stages (latency in clock cycles); legal range 1..16.
- RESET_VALUE, 0 (WIDTH bits, all zero), value loaded into every stage on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge only.
- i_rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- i_valor  input  WIDTH  data input, sampled every rising edge.
- o_valor  output  WIDTH  registered data output, equal to the last stage.

Behaviour:
- Stages s[0]..s[DEPTH-1], each WIDTH bits; o_valor = s[DEPTH-1], driven directly from a register (no combinational path from i_valor).
- Rising edge with i_rst_n=0: every stage <= RESET_VALUE. Reset wins over data. o_valor = RESET_VALUE from that edge on.
- Rising edge with i_rst_n=1: s[0] <= i_valor; s[k] <= s[k-1] for k=1..DEPTH-1.
- Latency: a value on i_valor at edge N appears on o_valor after edge N+DEPTH-1 (DEPTH=1: visible right after edge N, stable for a full cycle).
- Reset is not asynchronous: asserting i_rst_n between edges does not change o_valor until the next rising edge.
- Deasserting i_rst_n: the first edge with i_rst_n=1 captures i_valor into s[0]. Remaining stages still hold RESET_VALUE and shift out over the following DEPTH-1 edges.
- Reset mid-stream: all in-flight data is discarded at the reset edge; nothing is preserved.
- Before the first reset edge the stage contents are undefined (X in simulation). No initial-value reliance.
- Inputs changing between edges have no effect. Glitches on i_valor away from the edge are ignored.
- No enable. Every non-reset edge shifts.
- Elaboration must fail (error) if WIDTH or DEPTH is outside its legal range.

Optional Feature:
- Macro FLIPFLOP_EDGE_EN.
- Defined: adds two outputs after o_valor: `o_rise` (WIDTH) and `o_fall` (WIDTH), both registered.
  - One extra register `p` holds the previous o_valor.
  - o_rise = o_valor & ~p, o_fall = ~o_valor & p, per bit, combinational from registers.
  - Reset loads p <= RESET_VALUE, so both outputs are 0 immediately after reset.
  - Each pulse is high for exactly one clock per transition.
- Undefined: the ports and register p are absent. Behaviour of o_valor is identical in both builds.

Test Plan:
- Reset: i_rst_n=0 for 2 edges with i_valor=1 (WIDTH=1) -> o_valor=0 after the first edge. Drop i_rst_n mid-cycle with no edge -> o_valor unchanged until the next edge.
- Toggle, DEPTH=1, clk period 40 ns: i_valor=0 then 1 at 20 ns, inverted every 140 ns -> o_valor follows i_valor, updating only at rising edges, delayed by at most one cycle, never changing between edges.
- Latency, DEPTH=3, WIDTH=8: drive 0x11, 0x22, 0x33, 0x44 on consecutive edges -> o_valor shows 0x11 right after the 3rd of those edges, then 0x22, 0x33, 0x44 on successive edges.
- Reset mid-stream, DEPTH=3, RESET_VALUE=0xA5: assert i_rst_n=0 while 0x11 and 0x22 are in flight -> o_valor=0xA5 at that edge. After release, 0xA5 persists for DEPTH-1 edges before new data appears.
- Edge detect (FLIPFLOP_EDGE_EN), WIDTH=1: o_valor sequence 0,1,1,0 -> o_rise=0,1,0,0 and o_fall=0,0,0,1. Both 0 on the cycle after reset.

Source files
------------

// File: rtl/flipflop.sv
// flipflop: parameterised D-type register / delay line.
//   WIDTH-bit data, DEPTH cascaded stages, synchronous active-low clear that
//   loads RESET_VALUE into every stage. Default build is a single 1-bit DFF.
//   Optional macro FLIPFLOP_EDGE_EN adds registered rise/fall pulse outputs
//   (o_rise, o_fall) derived from o_valor and its previous value.
module flipflop #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_valor,
`ifdef FLIPFLOP_EDGE_EN
    output logic [WIDTH-1:0] o_valor,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
`else
    output logic [WIDTH-1:0] o_valor
`endif
);

    // Refuse to build outside the supported parameter envelope.
    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("flipflop: WIDTH must be in 1..64");
        end
        if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
            $error("flipflop: DEPTH must be in 1..16");
        end
    endgenerate

    // Stage 0 takes the input; every later stage takes its predecessor.
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_d[gi] = i_valor;
            end else begin : g_tail
                assign stage_d[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    // Shift the whole line every edge; reset clears all in-flight data.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            stage_q <= '{default: RESET_VALUE};
        end else begin
            stage_q <= stage_d;
        end
    end

    // Output comes straight from the last register, no path from i_valor.
    assign o_valor = stage_q[DEPTH-1];

`ifdef FLIPFLOP_EDGE_EN
    logic [WIDTH-1:0] prev_q;

    // Remember last cycle's output; reset matches o_valor so no pulse follows reset.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            prev_q <= RESET_VALUE;
        end else begin
            prev_q <= stage_q[DEPTH-1];
        end
    end

    // Per-bit transitions: both operands are registers, so pulses last one clock.
    assign o_rise = stage_q[DEPTH-1] & ~prev_q;
    assign o_fall = ~stage_q[DEPTH-1] & prev_q;
`endif

endmodule

// File: tb/tb_flipflop.sv
// tb_flipflop: directed checks of flipflop in two configurations:
//   dut1: WIDTH=1, DEPTH=1, RESET_VALUE=0 (default DFF)
//   dut3: WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5 (delay line)
// When FLIPFLOP_EDGE_EN is defined the rise/fall outputs are checked as well.
module tb_flipflop;

    logic       clk;
    logic       rst1_n;
    logic       rst3_n;
    logic [0:0] d1;
    logic [7:0] d8;
    logic [0:0] q1;
    logic [7:0] q8;
`ifdef FLIPFLOP_EDGE_EN
    logic [0:0] rise1, fall1;
    logic [7:0] rise8, fall8;
`endif

    int checks   = 0;
    int failures = 0;

    flipflop #(
        .WIDTH      (1),
        .DEPTH      (1),
        .RESET_VALUE(1'b0)
    ) dut1 (
        .clk    (clk),
        .i_rst_n(rst1_n),
        .i_valor(d1),
`ifdef FLIPFLOP_EDGE_EN
        .o_valor(q1),
        .o_rise (rise1),
        .o_fall (fall1)
`else
        .o_valor(q1)
`endif
    );

    flipflop #(
        .WIDTH      (8),
        .DEPTH      (3),
        .RESET_VALUE(8'hA5)
    ) dut3 (
        .clk    (clk),
        .i_rst_n(rst3_n),
        .i_valor(d8),
`ifdef FLIPFLOP_EDGE_EN
        .o_valor(q8),
        .o_rise (rise8),
        .o_fall (fall8)
`else
        .o_valor(q8)
`endif
    );

    // 40 ns period, first rising edge at 20 ns.
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("chk %s observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Hold both in reset with non-reset-looking data on the inputs.
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        d1     = 1'b1;
        d8     = 8'h5A;

        tick();
        check("rst1_edge1", 64'(q1), 64'h0);
        check("rst3_edge1", 64'(q8), 64'hA5);
        tick();
        check("rst1_edge2", 64'(q1), 64'h0);
        check("rst3_edge2", 64'(q8), 64'hA5);

        // Release reset between edges: nothing changes until the next edge.
        rst1_n = 1'b1;
        #10;
        check("rel_no_edge", 64'(q1), 64'h0);
        tick();
        check("rel_capture", 64'(q1), 64'h1);

        // Assert reset between edges: output holds until the next edge.
        rst1_n = 1'b0;
        #10;
        check("rst_no_edge", 64'(q1), 64'h1);
        tick();
        check("rst_applied", 64'(q1), 64'h0);
        rst1_n = 1'b1;

        // Toggle pattern: output stable between edges, follows input at edges,
        // and a glitch on the input away from the edge is ignored.
        begin
            logic [7:0] pat;
            logic       prev;
            pat  = 8'b1011_0010;
            prev = 1'b0;
            for (int i = 0; i < 8; i++) begin
                d1 = pat[i];
                #5;
                d1 = ~pat[i];
                #5;
                d1 = pat[i];
                check($sformatf("tog_hold%0d", i), 64'(q1), 64'(prev));
                tick();
                check($sformatf("tog_edge%0d", i), 64'(q1), 64'(pat[i]));
                prev = pat[i];
            end
        end

        // Latency on the 3-stage line: reset value drains for two edges first.
        rst3_n = 1'b1;
        d8 = 8'h11; tick(); check("lat_e1", 64'(q8), 64'hA5);
        d8 = 8'h22; tick(); check("lat_e2", 64'(q8), 64'hA5);
        d8 = 8'h33; tick(); check("lat_e3", 64'(q8), 64'h11);
        d8 = 8'h44; tick(); check("lat_e4", 64'(q8), 64'h22);
        d8 = 8'h55; tick(); check("lat_e5", 64'(q8), 64'h33);
        d8 = 8'h11; tick(); check("lat_e6", 64'(q8), 64'h44);
        d8 = 8'h22; tick(); check("lat_e7", 64'(q8), 64'h55);

        // Reset while 0x11 and 0x22 are in flight: everything is discarded.
        rst3_n = 1'b0;
        d8 = 8'h33; tick(); check("mid_rst", 64'(q8), 64'hA5);
        rst3_n = 1'b1;
        d8 = 8'h66; tick(); check("post_e1", 64'(q8), 64'hA5);
        d8 = 8'h77; tick(); check("post_e2", 64'(q8), 64'hA5);
        d8 = 8'h88; tick(); check("post_e3", 64'(q8), 64'h66);
        d8 = 8'h99; tick(); check("post_e4", 64'(q8), 64'h77);
        tick();             check("post_e5", 64'(q8), 64'h88);

`ifdef FLIPFLOP_EDGE_EN
        // Edge detect: after reset both pulses are low; then o_valor 0,1,1,0.
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        d1 = 1'b1;
        tick();
        check("edg_rst_rise1", 64'(rise1), 64'h0);
        check("edg_rst_fall1", 64'(fall1), 64'h0);
        check("edg_rst_rise8", 64'(rise8), 64'h0);
        check("edg_rst_fall8", 64'(fall8), 64'h0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        begin
            logic [3:0] seq, exp_r, exp_f;
            seq   = 4'b0110;
            exp_r = 4'b0010;
            exp_f = 4'b1000;
            for (int i = 0; i < 4; i++) begin
                d1 = seq[i];
                tick();
                check($sformatf("edg_q%0d", i),    64'(q1),    64'(seq[i]));
                check($sformatf("edg_rise%0d", i), 64'(rise1), 64'(exp_r[i]));
                check($sformatf("edg_fall%0d", i), 64'(fall1), 64'(exp_f[i]));
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
